// File: rtl/plic_mt_pkg.sv
// Shared types, defaults and helpers for the multi-target PLIC core.
package plic_mt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    SERV = 2'd2
  } gw_state_e;

  localparam int DEF_NUM_SRC    = 31;
  localparam int DEF_NUM_TGT    = 2;
  localparam int DEF_PRIO_WIDTH = 3;
  localparam int DEF_EDGE_CNT_W = 2;

  // Id 0 is reserved for "no source", hence the +1.
  function automatic int id_width(input int num_src);
    return $clog2(num_src + 1);
  endfunction

endpackage

// File: rtl/plic_gateway.sv
// Per-source gateway: level/edge qualification, saturating edge count and
// the IDLE/PEND/SERV handshake with the claim/complete decode.
module plic_gateway
  import plic_mt_pkg::*;
#(
  parameter int EDGE_CNT_W = DEF_EDGE_CNT_W
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic irq_i,
  input  logic trig_mode_i,
  input  logic claim_hit,
  input  logic comp_hit,
  output logic ip,
  output logic ip_nxt
);

  localparam logic [EDGE_CNT_W-1:0] CNT_MAX = '1;

  gw_state_e             state_q, state_d;
  logic                  prev_q, prev_d;
  logic [EDGE_CNT_W-1:0] cnt_q, cnt_d;
  logic                  rise;
  logic                  dec;

  always_comb begin
    state_d = state_q;
    prev_d  = irq_i;
    cnt_d   = cnt_q;
    rise    = irq_i & ~prev_q;
    dec     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (trig_mode_i) begin
          if (cnt_q != '0) begin
            state_d = PEND;
            dec     = 1'b1;
          end
        end else if (irq_i) begin
          state_d = PEND;
        end
      end
      PEND:    if (claim_hit) state_d = SERV;
      SERV:    if (comp_hit)  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // An edge arriving with a decrement cancels out, even at saturation.
    if (!trig_mode_i) begin
      cnt_d = '0;
    end else if (rise && !dec) begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + EDGE_CNT_W'(1);
    end else if (!rise && dec) begin
      cnt_d = cnt_q - EDGE_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ip     = (state_q == PEND);
  assign ip_nxt = (state_d == PEND);

endmodule

// File: rtl/plic_mt_core.sv
// Multi-target PLIC core: gateways per source, claim/complete decode and
// registered per-target arbitration fed from next-state pending bits.
module plic_mt_core
  import plic_mt_pkg::*;
#(
  parameter  int NUM_SRC    = DEF_NUM_SRC,
  parameter  int NUM_TGT    = DEF_NUM_TGT,
  parameter  int PRIO_WIDTH = DEF_PRIO_WIDTH,
  parameter  int EDGE_CNT_W = DEF_EDGE_CNT_W,
  localparam int ID_W       = id_width(NUM_SRC)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_SRC-1:0]            irq_i,
  input  logic [NUM_SRC-1:0]            trig_mode_i,
  input  logic [NUM_SRC*PRIO_WIDTH-1:0] prio_i,
  input  logic [NUM_TGT*NUM_SRC-1:0]    ie_i,
  input  logic [NUM_TGT*PRIO_WIDTH-1:0] thold_i,
  input  logic [NUM_TGT-1:0]            claim_i,
  input  logic [NUM_TGT-1:0]            comp_i,
  input  logic [NUM_TGT*ID_W-1:0]       comp_id_i,
  output logic [NUM_SRC-1:0]            ip_o,
  output logic [NUM_TGT*ID_W-1:0]       claim_id_o,
  output logic [NUM_TGT-1:0]            irq_o
);

  logic [NUM_SRC-1:0]            claim_hit;
  logic [NUM_SRC-1:0]            comp_hit;
  logic [NUM_SRC-1:0]            ip_cur;
  logic [NUM_SRC-1:0]            ip_nxt;
  logic [NUM_TGT-1:0][ID_W-1:0]  claim_id_q, claim_id_d, claim_id_m;
  logic [NUM_TGT-1:0]            irq_q, irq_d;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_gw
    plic_gateway #(.EDGE_CNT_W(EDGE_CNT_W)) u_gw (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .irq_i       (irq_i[k]),
      .trig_mode_i (trig_mode_i[k]),
      .claim_hit   (claim_hit[k]),
      .comp_hit    (comp_hit[k]),
      .ip          (ip_cur[k]),
      .ip_nxt      (ip_nxt[k])
    );
  end

  // Claims use the masked ids, so a losing target can never hit a source.
  always_comb begin
    claim_hit = '0;
    comp_hit  = '0;
    for (int t = 0; t < NUM_TGT; t++) begin
      for (int k = 0; k < NUM_SRC; k++) begin
        if (claim_i[t] && claim_id_m[t] == ID_W'(k + 1))
          claim_hit[k] = 1'b1;
        if (comp_i[t] && comp_id_i[t*ID_W +: ID_W] == ID_W'(k + 1) &&
            ie_i[t*NUM_SRC + k])
          comp_hit[k] = 1'b1;
      end
    end
  end

  for (genvar t = 0; t < NUM_TGT; t++) begin : g_arb
    logic [PRIO_WIDTH-1:0] best_prio;
    logic [ID_W-1:0]       best_id;
    logic [ID_W-1:0]       masked_id;

    // Strict compare keeps the lowest id on ties; prio 0 never qualifies.
    always_comb begin
      best_prio = '0;
      best_id   = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
        if (ip_nxt[k] && ie_i[t*NUM_SRC + k] &&
            prio_i[k*PRIO_WIDTH +: PRIO_WIDTH] > best_prio) begin
          best_prio = prio_i[k*PRIO_WIDTH +: PRIO_WIDTH];
          best_id   = ID_W'(k + 1);
        end
      end
    end

    always_comb begin
      masked_id = claim_id_q[t];
      for (int j = 0; j < t; j++) begin
        if (claim_i[j] && claim_id_q[j] != '0 && claim_id_q[j] == claim_id_q[t])
          masked_id = '0;
      end
    end

    assign claim_id_d[t] = best_id;
    assign irq_d[t]      = (best_id != '0) &&
                           (best_prio > thold_i[t*PRIO_WIDTH +: PRIO_WIDTH]);
    assign claim_id_m[t] = masked_id;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      claim_id_q <= '0;
      irq_q      <= '0;
    end else begin
      claim_id_q <= claim_id_d;
      irq_q      <= irq_d;
    end
  end

  assign ip_o       = ip_cur;
  assign claim_id_o = claim_id_m;
  assign irq_o      = irq_q;

endmodule

// File: tb/tb_plic_mt_core.sv
// Directed bench for plic_mt_core with 31 sources and 2 targets.
module tb_plic_mt_core;
  localparam int NS = 31;
  localparam int NT = 2;
  localparam int PW = 3;
  localparam int IW = 5;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [NS-1:0]   irq_i, trig_mode_i, ip_o;
  logic [NS*PW-1:0] prio_i;
  logic [NT*NS-1:0] ie_i;
  logic [NT*PW-1:0] thold_i;
  logic [NT-1:0]   claim_i, comp_i, irq_o;
  logic [NT*IW-1:0] comp_id_i, claim_id_o;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk_i = ~clk_i;

  plic_mt_core #(.NUM_SRC(NS), .NUM_TGT(NT), .PRIO_WIDTH(PW), .EDGE_CNT_W(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .irq_i(irq_i), .trig_mode_i(trig_mode_i),
    .prio_i(prio_i), .ie_i(ie_i), .thold_i(thold_i), .claim_i(claim_i),
    .comp_i(comp_i), .comp_id_i(comp_id_i), .ip_o(ip_o),
    .claim_id_o(claim_id_o), .irq_o(irq_o)
  );

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic set_prio(input int src, input int p);
    prio_i[(src-1)*PW +: PW] = PW'(p);
  endtask

  task automatic set_ie(input int t, input int src);
    ie_i[t*NS + src - 1] = 1'b1;
  endtask

  function automatic logic [IW-1:0] cid(input int t);
    return claim_id_o[t*IW +: IW];
  endfunction

  task automatic do_claim(input int t);
    claim_i[t] = 1'b1; tick(); claim_i = '0;
  endtask

  task automatic do_comp(input int t, input int id);
    comp_i[t] = 1'b1; comp_id_i[t*IW +: IW] = IW'(id); tick();
    comp_i = '0; comp_id_i = '0;
  endtask

  task automatic clean_reset();
    irq_i = '0; trig_mode_i = '0; prio_i = '0; ie_i = '0; thold_i = '0;
    claim_i = '0; comp_i = '0; comp_id_i = '0;
    rst_i = 1'b1; tick(); rst_i = 1'b0;
  endtask

  task automatic test_reset();
    irq_i = '1; trig_mode_i = '0; prio_i = '1; ie_i = '1; thold_i = '0;
    claim_i = '0; comp_i = '0; comp_id_i = '0;
    rst_i = 1'b1; tick(); tick();
    total_cnt++; if (ip_o !== '0) $display("FAIL reset_ip: got %h want 0", ip_o); else pass_cnt++;
    total_cnt++; if (irq_o !== '0) $display("FAIL reset_irq: got %b want 0", irq_o); else pass_cnt++;
    total_cnt++; if (claim_id_o !== '0) $display("FAIL reset_claim_id: got %h want 0", claim_id_o); else pass_cnt++;
    irq_i = '0; rst_i = 1'b0;
  endtask

  task automatic test_level();
    clean_reset();
    set_prio(5, 3); set_ie(0, 5); thold_i[0 +: PW] = 3'd1;
    irq_i[4] = 1'b1; tick();
    total_cnt++; if (ip_o[4] !== 1'b1) $display("FAIL level_ip: got %b want 1", ip_o[4]); else pass_cnt++;
    total_cnt++; if (irq_o[0] !== 1'b1) $display("FAIL level_irq0: got %b want 1", irq_o[0]); else pass_cnt++;
    total_cnt++; if (cid(0) !== 5'd5) $display("FAIL level_claim_id: got %0d want 5", cid(0)); else pass_cnt++;
    total_cnt++; if (irq_o[1] !== 1'b0) $display("FAIL level_irq1: got %b want 0", irq_o[1]); else pass_cnt++;
    do_claim(0);
    total_cnt++; if (ip_o[4] !== 1'b0) $display("FAIL level_claim_ip: got %b want 0", ip_o[4]); else pass_cnt++;
    total_cnt++; if (irq_o[0] !== 1'b0) $display("FAIL level_claim_irq: got %b want 0", irq_o[0]); else pass_cnt++;
    do_comp(0, 5);
    total_cnt++; if (ip_o[4] !== 1'b0) $display("FAIL level_comp_idle: got %b want 0", ip_o[4]); else pass_cnt++;
    tick();
    total_cnt++; if (ip_o[4] !== 1'b1) $display("FAIL level_repend: got %b want 1", ip_o[4]); else pass_cnt++;
  endtask

  task automatic test_arbitration();
    clean_reset();
    set_prio(3, 4); set_prio(7, 4); set_prio(9, 2);
    set_ie(0, 3); set_ie(0, 7); set_ie(0, 9);
    irq_i[2] = 1'b1; irq_i[6] = 1'b1; irq_i[8] = 1'b1; tick();
    total_cnt++; if (cid(0) !== 5'd3) $display("FAIL arb_first: got %0d want 3", cid(0)); else pass_cnt++;
    total_cnt++; if (irq_o[0] !== 1'b1) $display("FAIL arb_irq: got %b want 1", irq_o[0]); else pass_cnt++;
    thold_i[0 +: PW] = 3'd4; tick();
    total_cnt++; if (cid(0) !== 5'd3) $display("FAIL arb_thold_id: got %0d want 3", cid(0)); else pass_cnt++;
    total_cnt++; if (irq_o[0] !== 1'b0) $display("FAIL arb_thold_irq: got %b want 0", irq_o[0]); else pass_cnt++;
    thold_i = '0; tick();
    claim_i[0] = 1'b1; #1;
    total_cnt++; if (cid(0) !== 5'd3) $display("FAIL arb_b2b_0: got %0d want 3", cid(0)); else pass_cnt++;
    tick();
    total_cnt++; if (cid(0) !== 5'd7) $display("FAIL arb_b2b_1: got %0d want 7", cid(0)); else pass_cnt++;
    tick();
    total_cnt++; if (cid(0) !== 5'd9) $display("FAIL arb_b2b_2: got %0d want 9", cid(0)); else pass_cnt++;
    tick();
    total_cnt++; if (cid(0) !== 5'd0) $display("FAIL arb_b2b_3: got %0d want 0", cid(0)); else pass_cnt++;
    claim_i = '0;
  endtask

  task automatic test_edge_count();
    clean_reset();
    trig_mode_i[1] = 1'b1; set_prio(2, 5); set_ie(0, 2);
    irq_i[1] = 1'b1; tick();
    total_cnt++; if (ip_o[1] !== 1'b0) $display("FAIL edge_lat0: got %b want 0", ip_o[1]); else pass_cnt++;
    tick();
    total_cnt++; if (ip_o[1] !== 1'b1) $display("FAIL edge_lat1: got %b want 1", ip_o[1]); else pass_cnt++;
    do_claim(0);
    irq_i[1] = 1'b0; tick();
    for (int i = 0; i < 5; i++) begin
      irq_i[1] = 1'b1; tick();
      irq_i[1] = 1'b0; tick();
    end
    for (int r = 0; r < 3; r++) begin
      do_comp(0, 2); tick();
      total_cnt++; if (cid(0) !== 5'd2) $display("FAIL edge_round%0d: got %0d want 2", r, cid(0)); else pass_cnt++;
      do_claim(0);
    end
    do_comp(0, 2); tick();
    total_cnt++; if (cid(0) !== 5'd0) $display("FAIL edge_sat: got %0d want 0", cid(0)); else pass_cnt++;
  endtask

  task automatic test_dual_claim();
    clean_reset();
    set_prio(6, 2); set_ie(0, 6); set_ie(1, 6);
    irq_i[5] = 1'b1; tick();
    claim_i = 2'b11; #1;
    total_cnt++; if (cid(0) !== 5'd6) $display("FAIL dual_t0: got %0d want 6", cid(0)); else pass_cnt++;
    total_cnt++; if (cid(1) !== 5'd0) $display("FAIL dual_t1: got %0d want 0", cid(1)); else pass_cnt++;
    tick(); claim_i = '0;
    total_cnt++; if (ip_o[5] !== 1'b0) $display("FAIL dual_serv: got %b want 0", ip_o[5]); else pass_cnt++;
    comp_i = 2'b11; comp_id_i = {5'd6, 5'd6}; tick(); comp_i = '0; comp_id_i = '0;
    total_cnt++; if (ip_o[5] !== 1'b0) $display("FAIL dual_comp_idle: got %b want 0", ip_o[5]); else pass_cnt++;
    tick();
    total_cnt++; if (ip_o[5] !== 1'b1) $display("FAIL dual_comp_repend: got %b want 1", ip_o[5]); else pass_cnt++;
  endtask

  task automatic test_bad_complete();
    logic [NS-1:0] exp_ip;
    clean_reset();
    set_prio(5, 3); set_ie(0, 5); set_prio(8, 1); set_ie(0, 8);
    irq_i[4] = 1'b1; tick();
    do_claim(0);
    irq_i[7] = 1'b1;
    exp_ip = '0; exp_ip[7] = 1'b1;
    do_comp(0, 0); tick();
    total_cnt++; if (ip_o !== exp_ip) $display("FAIL bad_comp_id0: got %h want %h", ip_o, exp_ip); else pass_cnt++;
    do_comp(0, 8); tick();
    total_cnt++; if (ip_o !== exp_ip) $display("FAIL bad_comp_notserv: got %h want %h", ip_o, exp_ip); else pass_cnt++;
    do_comp(1, 5); tick();
    total_cnt++; if (ip_o !== exp_ip) $display("FAIL bad_comp_noie: got %h want %h", ip_o, exp_ip); else pass_cnt++;
    do_comp(0, 5); tick();
    exp_ip[4] = 1'b1;
    total_cnt++; if (ip_o !== exp_ip) $display("FAIL good_comp: got %h want %h", ip_o, exp_ip); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    clean_reset();
    trig_mode_i[1] = 1'b1; set_prio(2, 5); set_ie(0, 2);
    set_prio(5, 3); set_ie(1, 5);
    irq_i[1] = 1'b1; irq_i[4] = 1'b1; tick(); tick();
    claim_i = 2'b11; tick(); claim_i = '0;
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    total_cnt++; if (ip_o !== '0) $display("FAIL mid_rst_ip: got %h want 0", ip_o); else pass_cnt++;
    total_cnt++; if (irq_o !== '0) $display("FAIL mid_rst_irq: got %b want 0", irq_o); else pass_cnt++;
    total_cnt++; if (claim_id_o !== '0) $display("FAIL mid_rst_id: got %h want 0", claim_id_o); else pass_cnt++;
    tick();
    total_cnt++; if (ip_o[1] !== 1'b0) $display("FAIL mid_edge_lat0: got %b want 0", ip_o[1]); else pass_cnt++;
    total_cnt++; if (ip_o[4] !== 1'b1) $display("FAIL mid_level: got %b want 1", ip_o[4]); else pass_cnt++;
    tick();
    total_cnt++; if (ip_o[1] !== 1'b1) $display("FAIL mid_edge_repend: got %b want 1", ip_o[1]); else pass_cnt++;
    total_cnt++; if (cid(0) !== 5'd2) $display("FAIL mid_edge_id: got %0d want 2", cid(0)); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_level();
    test_arbitration();
    test_edge_count();
    test_dual_claim();
    test_bad_complete();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
